// File: rtl/pico_ctrl_pkg.sv
// Shared types and helpers for the picoMIPS run/step/breakpoint controller.
package pico_ctrl_pkg;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    BREAK = 2'd3
  } run_state_t;

  localparam int CNT_W = 16;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pico_debounce.sv
// Step push-button conditioning: 2-FF synchronizer, stability filter and
// a one-cycle pulse on each accepted rising level.
module pico_debounce
  import pico_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic n_reset,
  input  logic btn,
  output logic step_req
);

  localparam int CW = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // NOTE: every register here uses <= so all flops sample the same pre-edge
  // values; blocking assignments would collapse the synchronizer chain.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      level    <= 1'b0;
      cnt      <= '0;
      step_req <= 1'b0;
    end else begin
      sync1    <= btn;
      sync2    <= sync1;
      step_req <= 1'b0;
      // A sample agreeing with the accepted level restarts the stability count.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level    <= sync2;
        cnt      <= '0;
        step_req <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pico_run_ctrl.sv
// Run/step/breakpoint scheduler: produces a single-cycle clock-enable for the
// picoMIPS core and exports state and pulse count for the board display.
module pico_run_ctrl
  import pico_ctrl_pkg::*;
#(
  parameter int DIV       = 5_000_000,
  parameter int DB_CYCLES = 1_000_000,
  parameter int PC_W      = 8
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_en,
  output logic [1:0]       state_o,
  output logic             brk_hit,
  output logic [CNT_W-1:0] step_cnt
);

  localparam int PRE_W = cnt_width(DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  run_state_t       state;
  logic [PRE_W-1:0] presc;
  logic             tick_d;
  logic             run_s1;
  logic             run_sync;
  logic             bp_s1;
  logic             bp_en_sync;
  logic             step_req;
  logic             bp_match;

  pico_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .n_reset  (n_reset),
    .btn      (step_btn),
    .step_req (step_req)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      run_s1     <= 1'b0;
      run_sync   <= 1'b0;
      bp_s1      <= 1'b0;
      bp_en_sync <= 1'b0;
    end else begin
      run_s1     <= run_sw;
      run_sync   <= run_s1;
      bp_s1      <= bp_en;
      bp_en_sync <= bp_s1;
    end
  end

  // pc reflects the core one cycle after cpu_en, hence the delayed tick.
  assign bp_match = tick_d & bp_en_sync & (pc == bp_addr);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state    <= HALT;
      presc    <= '0;
      cpu_en   <= 1'b0;
      tick_d   <= 1'b0;
      step_cnt <= '0;
    end else begin
      cpu_en <= 1'b0;
      tick_d <= cpu_en;
      unique case (state)
        HALT: begin
          if (step_req) begin
            state    <= STEP;
            cpu_en   <= 1'b1;
            step_cnt <= step_cnt + CNT_W'(1);
          end else if (run_sync) begin
            state <= RUN;
            presc <= '0;
          end
        end
        STEP: state <= HALT;
        RUN: begin
          // Leaving RUN wins over a terminal count so no pulse escapes on halt.
          if (!run_sync) begin
            state <= HALT;
          end else if (bp_match) begin
            state <= BREAK;
          end else if (presc == PRE_LAST) begin
            presc    <= '0;
            cpu_en   <= 1'b1;
            step_cnt <= step_cnt + CNT_W'(1);
          end else begin
            presc <= presc + PRE_W'(1);
          end
        end
        BREAK: begin
          if (!run_sync) begin
            state <= HALT;
          end else if (step_req) begin
            state    <= STEP;
            cpu_en   <= 1'b1;
            step_cnt <= step_cnt + CNT_W'(1);
          end
        end
        default: state <= HALT;
      endcase
    end
  end

  assign state_o = state;
  assign brk_hit = (state == BREAK);

endmodule

// File: tb/tb_pico_run_ctrl.sv
// Directed bench for pico_run_ctrl (DIV=4, DB_CYCLES=3) plus a DIV=1 instance
// used for the step counter wrap and a second asynchronous reset.
module tb_pico_run_ctrl;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        run_sw;
  logic        step_btn;
  logic        bp_en;
  logic [7:0]  bp_addr;
  logic [7:0]  pc;
  logic        cpu_en;
  logic [1:0]  state_o;
  logic        brk_hit;
  logic [15:0] step_cnt;

  logic        rst2_n;
  logic        cpu_en2;
  logic [1:0]  state2;
  logic        brk_hit2;
  logic [15:0] cnt2;

  int n_pass   = 0;
  int n_checks = 0;
  int n_en     = 0;
  int base     = 0;

  always #5 clk = ~clk;

  pico_run_ctrl #(.DIV(4), .DB_CYCLES(3), .PC_W(8)) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .run_sw   (run_sw),
    .step_btn (step_btn),
    .bp_en    (bp_en),
    .bp_addr  (bp_addr),
    .pc       (pc),
    .cpu_en   (cpu_en),
    .state_o  (state_o),
    .brk_hit  (brk_hit),
    .step_cnt (step_cnt)
  );

  pico_run_ctrl #(.DIV(1), .DB_CYCLES(1), .PC_W(8)) u_wrap (
    .clk      (clk),
    .n_reset  (rst2_n),
    .run_sw   (1'b1),
    .step_btn (1'b0),
    .bp_en    (1'b0),
    .bp_addr  (8'h00),
    .pc       (8'h00),
    .cpu_en   (cpu_en2),
    .state_o  (state2),
    .brk_hit  (brk_hit2),
    .step_cnt (cnt2)
  );

  // Core model: pc advances on every enabled cycle.
  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) pc <= 8'h00;
    else if (cpu_en) pc <= pc + 8'h01;
  end

  always @(negedge clk) if (cpu_en) n_en++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_reset = 1'b0; rst2_n = 1'b0;
    run_sw = 1'b1; step_btn = 1'b0; bp_en = 1'b0; bp_addr = 8'h05;

    // 1. Reset and free run
    cyc(3);
    check("rst_cpu_en", 32'(cpu_en), 0);
    check("rst_state", 32'(state_o), 0);
    check("rst_step_cnt", 32'(step_cnt), 0);
    check("rst_brk_hit", 32'(brk_hit), 0);
    n_reset = 1'b1;
    cyc(2); check("sync_still_halt", 32'(state_o), 0);
    cyc(1); check("run_entry", 32'(state_o), 1);
    check("run_entry_no_en", 32'(cpu_en), 0);
    cyc(3); check("pre_first_tick", 32'(cpu_en), 0);
    cyc(1); check("first_tick", 32'(cpu_en), 1);
    check("first_tick_cnt", 32'(step_cnt), 1);
    cyc(1); check("tick_one_cycle", 32'(cpu_en), 0);
    cyc(3); check("second_tick", 32'(cpu_en), 1);
    check("second_tick_cnt", 32'(step_cnt), 2);

    // 2. Halt, single step, glitch rejection
    run_sw = 1'b0;
    cyc(4); check("halted", 32'(state_o), 0);
    check("halted_cnt", 32'(step_cnt), 2);
    base = n_en; step_btn = 1'b1;
    cyc(5); check("step_pre_state", 32'(state_o), 0);
    check("step_pre_en", 32'(cpu_en), 0);
    cyc(1); check("step_state", 32'(state_o), 2);
    check("step_en", 32'(cpu_en), 1);
    check("step_cnt_inc", 32'(step_cnt), 3);
    step_btn = 1'b0;
    cyc(1); check("step_back_halt", 32'(state_o), 0);
    check("step_en_drop", 32'(cpu_en), 0);
    cyc(8); check("step_single_pulse", 32'(n_en - base), 1);
    base = n_en; step_btn = 1'b1;
    cyc(2); step_btn = 1'b0;
    cyc(10); check("glitch_no_pulse", 32'(n_en - base), 0);
    check("glitch_cnt", 32'(step_cnt), 3);
    check("glitch_state", 32'(state_o), 0);

    // 3. Bouncing press
    base = n_en;
    step_btn = 1'b1; cyc(1); step_btn = 1'b0; cyc(1);
    step_btn = 1'b1; cyc(1); step_btn = 1'b0; cyc(1);
    step_btn = 1'b1;
    cyc(5); check("bounce_wait", 32'(n_en - base), 0);
    check("bounce_wait_state", 32'(state_o), 0);
    cyc(1); check("bounce_step_state", 32'(state_o), 2);
    check("bounce_step_cnt", 32'(step_cnt), 4);
    cyc(10); check("bounce_one_step", 32'(n_en - base), 1);
    step_btn = 1'b0;
    cyc(8);

    // 4. Breakpoint at pc 5
    n_reset = 1'b0; run_sw = 1'b0; bp_en = 1'b1; bp_addr = 8'h05;
    cyc(1);
    n_reset = 1'b1; run_sw = 1'b1;
    check("bp_reset_cnt", 32'(step_cnt), 0);
    cyc(3); check("bp_run_entry", 32'(state_o), 1);
    cyc(21); check("bp_pre_state", 32'(state_o), 1);
    check("bp_pc", 32'(pc), 5);
    check("bp_pre_cnt", 32'(step_cnt), 5);
    cyc(1); check("bp_state", 32'(state_o), 3);
    check("bp_brk_hit", 32'(brk_hit), 1);
    base = n_en;
    cyc(8); check("bp_no_en", 32'(n_en - base), 0);
    check("bp_hold", 32'(state_o), 3);
    check("bp_hold_cnt", 32'(step_cnt), 5);
    step_btn = 1'b1;
    cyc(5); check("bp_step_wait", 32'(state_o), 3);
    cyc(1); check("bp_step_state", 32'(state_o), 2);
    check("bp_step_en", 32'(cpu_en), 1);
    check("bp_step_cnt", 32'(step_cnt), 6);
    step_btn = 1'b0;
    cyc(1); check("bp_step_halt", 32'(state_o), 0);
    check("bp_step_pc", 32'(pc), 6);
    check("bp_brk_clear", 32'(brk_hit), 0);
    cyc(1); check("bp_resume_run", 32'(state_o), 1);

    // 5. Halt colliding with the prescaler terminal count
    cyc(4); check("col_tick", 32'(cpu_en), 1);
    check("col_tick_cnt", 32'(step_cnt), 7);
    cyc(1); run_sw = 1'b0;
    cyc(2); check("col_still_run", 32'(state_o), 1);
    cyc(1); check("col_state", 32'(state_o), 0);
    check("col_no_en", 32'(cpu_en), 0);
    check("col_cnt", 32'(step_cnt), 7);
    cyc(1); check("col_after_en", 32'(cpu_en), 0);

    // 6a. Asynchronous reset while a pulse is high
    run_sw = 1'b1;
    cyc(7); check("ar_tick", 32'(cpu_en), 1);
    check("ar_tick_cnt", 32'(step_cnt), 8);
    #2 n_reset = 1'b0;
    #1;
    check("ar_cpu_en", 32'(cpu_en), 0);
    check("ar_state", 32'(state_o), 0);
    check("ar_brk_hit", 32'(brk_hit), 0);
    check("ar_step_cnt", 32'(step_cnt), 0);

    // 6b. Counter wrap at DIV=1, then reset mid-count
    cyc(1); rst2_n = 1'b1;
    cyc(65538); check("wrap_ffff", 32'(cnt2), 32'h0000_FFFF);
    check("wrap_div1_en", 32'(cpu_en2), 1);
    cyc(1); check("wrap_zero", 32'(cnt2), 0);
    check("wrap_state", 32'(state2), 1);
    cyc(1); check("wrap_one", 32'(cnt2), 1);
    #2 rst2_n = 1'b0;
    #1;
    check("ar2_cpu_en", 32'(cpu_en2), 0);
    check("ar2_state", 32'(state2), 0);
    check("ar2_brk_hit", 32'(brk_hit2), 0);
    check("ar2_cnt", 32'(cnt2), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
